// File: rtl/datapath_pkg.sv
// Shared types and constants for the dispatch stage.
//   NFU rows/function units, tag encoding (tag = fu index + 1, 0 = ready),
//   register widths and the FUST row payload bundle.
package datapath_pkg;

   localparam int unsigned NSREG    = 32;
   localparam int unsigned NMREG    = 16;
   localparam int unsigned NFU      = 5;
   localparam int unsigned TAG_W    = 3;
   localparam int unsigned PAY_W    = 64;
   localparam int unsigned NSRC     = 3;
   localparam int unsigned SREG_W   = $clog2(NSREG);
   localparam int unsigned MREG_W   = $clog2(NMREG);
   localparam int unsigned FU_IDX_W = 3;

   typedef enum logic [FU_IDX_W-1:0] {
      FU_ALU     = 3'd0,
      FU_LD_ST   = 3'd1,
      FU_BRANCH  = 3'd2,
      FU_M_LD_ST = 3'd3,
      FU_GEMM    = 3'd4
   } fu_idx_e;

   typedef logic [TAG_W-1:0]  tag_t;
   typedef logic [SREG_W-1:0] reg_t;

   // Everything the FUST latches for one row besides the write strobe.
   typedef struct packed {
      reg_t [NSRC-1:0]   rs;
      tag_t [NSRC-1:0]   t;
      reg_t              rd;
      logic [PAY_W-1:0]  payload;
   } dispatch_row_t;

   // Tag produced by a function unit: its index plus one, so 0 stays "ready".
   function automatic tag_t fu_tag(input logic [FU_IDX_W-1:0] fu);
      return TAG_W'(fu) + TAG_W'(1);
   endfunction

endpackage

// File: rtl/dispatch_if.sv
// Dispatch bundle: decoded-instruction handshake, FUST write port,
// writeback/release retirement inputs, freeze/flush control and busy vector.
//   slave  : the dispatch stage
//   master : the surrounding pipeline (decode/FUST/writeback)
interface dispatch_if;
   import datapath_pkg::*;

   logic                          in_valid;
   logic                          in_ready;
   logic [FU_IDX_W-1:0]           in_fu;
   logic [SREG_W-1:0]             in_rd;
   logic                          in_rd_en;
   logic                          in_rd_mat;
   logic [NSRC-1:0][SREG_W-1:0]   in_rs;
   logic [NSRC-1:0]               in_rs_en;
   logic [NSRC-1:0]               in_rs_mat;
   logic [PAY_W-1:0]              in_payload;

   logic [NFU-1:0]                fust_we;
   logic [NSRC-1:0][SREG_W-1:0]   fust_rs;
   logic [NSRC-1:0][TAG_W-1:0]    fust_t;
   logic [SREG_W-1:0]             fust_rd;
   logic [PAY_W-1:0]              fust_payload;

   logic [NFU-1:0]                fu_release;
   logic                          wb_valid;
   logic [TAG_W-1:0]              wb_tag;
   logic                          freeze;
   logic                          flush;
   logic [NFU-1:0]                busy;

   modport slave (
      input  in_valid, in_fu, in_rd, in_rd_en, in_rd_mat,
             in_rs, in_rs_en, in_rs_mat, in_payload,
             fu_release, wb_valid, wb_tag, freeze, flush,
      output in_ready, fust_we, fust_rs, fust_t, fust_rd, fust_payload, busy
   );

   modport master (
      output in_valid, in_fu, in_rd, in_rd_en, in_rd_mat,
             in_rs, in_rs_en, in_rs_mat, in_payload,
             fu_release, wb_valid, wb_tag, freeze, flush,
      input  in_ready, fust_we, fust_rs, fust_t, fust_rd, fust_payload, busy
   );

endinterface

// File: rtl/rst_table.sv
// Register result status table: one producing tag per architectural register.
//   CLK, nRST          : clock, async active-low reset
//   flush              : clear every entry on the next edge
//   rd_addr/rd_tag_c   : NRD combinational read ports, writeback-bypassed
//   set_en/addr/tag    : record a new producer (wins over a same-edge clear)
//   clr_en/clr_tag     : broadcast retire of a tag to every matching entry
// ZERO_REG pins entry 0 to tag 0 (hardwired-zero register).
module rst_table
   import datapath_pkg::*;
#(
   parameter int unsigned DEPTH    = 32,
   parameter int unsigned NRD      = 3,
   parameter bit          ZERO_REG = 1'b0,
   localparam int unsigned AW      = $clog2(DEPTH)
) (
   input  logic                   CLK,
   input  logic                   nRST,
   input  logic                   flush,
   input  logic [NRD-1:0][AW-1:0] rd_addr,
   output tag_t [NRD-1:0]         rd_tag_c,
   input  logic                   set_en,
   input  logic [AW-1:0]          set_addr,
   input  tag_t                   set_tag,
   input  logic                   clr_en,
   input  tag_t                   clr_tag
);

   tag_t [DEPTH-1:0] tbl;

   // Entry update: flush > set > matching-tag clear.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         tbl <= '0;
      end else begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (flush) begin
               tbl[i] <= '0;
            end else if (set_en && (set_addr == AW'(i)) && !(ZERO_REG && (i == 0))) begin
               tbl[i] <= set_tag;
            end else if (clr_en && (tbl[i] == clr_tag)) begin
               tbl[i] <= '0;
            end
         end
      end
   end

   // Reads see a tag completing this cycle as already ready.
   always_comb begin
      for (int unsigned r = 0; r < NRD; r++) begin
         tag_t t;
         t = tbl[rd_addr[r]];
         if (ZERO_REG && (rd_addr[r] == '0)) begin
            t = '0;
         end
         if (clr_en && (t == clr_tag)) begin
            t = '0;
         end
         rd_tag_c[r] = t;
      end
   end

endmodule

// File: rtl/dispatch.sv
// In-order dispatch stage upstream of issue.
//   CLK, nRST : clock, async active-low reset
//   dif       : dispatch_if.slave bundle (decode handshake, FUST write port,
//               writeback/release, freeze/flush, busy)
// Checks structural (row busy) and WAW (rd pending) hazards, writes the FUST
// row in the same cycle it accepts, and tracks producer tags in two RST tables.
module dispatch
   import datapath_pkg::*;
(
   input  logic     CLK,
   input  logic     nRST,
   dispatch_if.slave dif
);

   localparam int unsigned NRD = NSRC + 1;   // three sources plus the rd probe

   logic [NFU-1:0]               busy_q;
   logic [NFU-1:0]               sel_c;
   logic [NFU-1:0]               eb_c;
   logic                         legal_c;
   logic                         fu_busy_c;
   logic                         waw_c;
   logic                         ready_c;
   logic                         fire_c;
   tag_t                         dst_tag_c;
   tag_t                         set_tag_c;
   logic [NRD-1:0][SREG_W-1:0]   s_addr_c;
   logic [NRD-1:0][MREG_W-1:0]   m_addr_c;
   tag_t [NRD-1:0]               s_tag_c;
   tag_t [NRD-1:0]               m_tag_c;
   dispatch_row_t                row_c;

   // Target-row decode; an illegal index selects no row.
   always_comb begin
      for (int unsigned i = 0; i < NFU; i++) begin
         sel_c[i] = (dif.in_fu == FU_IDX_W'(i));
      end
   end

   // Table read addresses: sources first, destination probe last.
   always_comb begin
      for (int unsigned i = 0; i < NSRC; i++) begin
         s_addr_c[i] = dif.in_rs[i];
         m_addr_c[i] = dif.in_rs[i][MREG_W-1:0];
      end
      s_addr_c[NSRC] = dif.in_rd;
      m_addr_c[NSRC] = dif.in_rd[MREG_W-1:0];
   end

   // Hazard checks and handshake. A same-cycle release frees the row.
   always_comb begin
      legal_c   = (dif.in_fu < FU_IDX_W'(NFU));
      eb_c      = busy_q & ~dif.fu_release;
      fu_busy_c = |(eb_c & sel_c);
      dst_tag_c = dif.in_rd_mat ? m_tag_c[NSRC] : s_tag_c[NSRC];
      waw_c     = dif.in_rd_en && (dst_tag_c != '0);
      ready_c   = !dif.freeze && !dif.flush && !fu_busy_c && !waw_c && legal_c;
      fire_c    = dif.in_valid && ready_c;
      set_tag_c = fu_tag(dif.in_fu);
   end

   // FUST row contents; tags of unused sources read as ready.
   always_comb begin
      row_c.rs      = dif.in_rs;
      row_c.rd      = dif.in_rd;
      row_c.payload = dif.in_payload;
      for (int unsigned i = 0; i < NSRC; i++) begin
         if (!dif.in_rs_en[i]) begin
            row_c.t[i] = '0;
         end else if (dif.in_rs_mat[i]) begin
            row_c.t[i] = m_tag_c[i];
         end else begin
            row_c.t[i] = s_tag_c[i];
         end
      end
   end

   assign dif.in_ready     = ready_c;
   assign dif.fust_we      = {NFU{fire_c}} & sel_c;
   assign dif.fust_rs      = row_c.rs;
   assign dif.fust_t       = row_c.t;
   assign dif.fust_rd      = row_c.rd;
   assign dif.fust_payload = row_c.payload;
   assign dif.busy         = busy_q;

   // Row busy bits: set on dispatch beats a same-edge release.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         busy_q <= '0;
      end else if (dif.flush) begin
         busy_q <= '0;
      end else begin
         busy_q <= (busy_q & ~dif.fu_release) | ({NFU{fire_c}} & sel_c);
      end
   end

   // Scalar registers: x0 never pending.
   rst_table #(
      .DEPTH    (NSREG),
      .NRD      (NRD),
      .ZERO_REG (1'b1)
   ) u_srst (
      .CLK      (CLK),
      .nRST     (nRST),
      .flush    (dif.flush),
      .rd_addr  (s_addr_c),
      .rd_tag_c (s_tag_c),
      .set_en   (fire_c && dif.in_rd_en && !dif.in_rd_mat),
      .set_addr (dif.in_rd),
      .set_tag  (set_tag_c),
      .clr_en   (dif.wb_valid),
      .clr_tag  (dif.wb_tag)
   );

   // Matrix registers.
   rst_table #(
      .DEPTH    (NMREG),
      .NRD      (NRD),
      .ZERO_REG (1'b0)
   ) u_mrst (
      .CLK      (CLK),
      .nRST     (nRST),
      .flush    (dif.flush),
      .rd_addr  (m_addr_c),
      .rd_tag_c (m_tag_c),
      .set_en   (fire_c && dif.in_rd_en && dif.in_rd_mat),
      .set_addr (dif.in_rd[MREG_W-1:0]),
      .set_tag  (set_tag_c),
      .clr_en   (dif.wb_valid),
      .clr_tag  (dif.wb_tag)
   );

endmodule

// File: tb/tb_dispatch.sv
// Self-checking bench for dispatch: directed vector table, randomized traffic
// against a register-array reference model, and an async reset mid-stream.
module tb_dispatch;
   import datapath_pkg::*;

   logic CLK;
   logic nRST;
   int   checks = 0;
   int   errors = 0;

   dispatch_if dif();

   dispatch u_dut (
      .CLK  (CLK),
      .nRST (nRST),
      .dif  (dif)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached, got running, need finished");
      $fatal(1, "watchdog");
   end

   // Reference model: producer tag per register, busy flag per unit.
   int       srst_m [NSREG];
   int       mrst_m [NMREG];
   bit [4:0] busy_m;

   typedef struct {
      bit v; int fu; int rd; bit rd_en; bit rd_mat;
      int rs0; int rs1; int rs2; bit [2:0] rs_en; bit [2:0] rs_mat;
      bit [4:0] rel; bit wbv; int wbt; bit fl; bit fz;
      bit e_ready; bit [4:0] e_we; int e_t0; int e_t1; int e_t2; bit [4:0] e_busy;
   } vec_t;

   function automatic vec_t mk(bit v, int fu, int rd, bit rd_en, bit rd_mat,
                               int rs0, int rs1, int rs2, bit [2:0] rs_en, bit [2:0] rs_mat,
                               bit [4:0] rel, bit wbv, int wbt, bit fl, bit fz,
                               bit e_ready, bit [4:0] e_we, int e_t0, int e_t1, int e_t2,
                               bit [4:0] e_busy);
      vec_t x;
      x.v = v; x.fu = fu; x.rd = rd; x.rd_en = rd_en; x.rd_mat = rd_mat;
      x.rs0 = rs0; x.rs1 = rs1; x.rs2 = rs2; x.rs_en = rs_en; x.rs_mat = rs_mat;
      x.rel = rel; x.wbv = wbv; x.wbt = wbt; x.fl = fl; x.fz = fz;
      x.e_ready = e_ready; x.e_we = e_we; x.e_t0 = e_t0; x.e_t1 = e_t1; x.e_t2 = e_t2;
      x.e_busy = e_busy;
      return x;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, need %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic idle();
      dif.in_valid = 1'b0; dif.in_fu = '0; dif.in_rd = '0; dif.in_rd_en = 1'b0;
      dif.in_rd_mat = 1'b0; dif.in_rs = '0; dif.in_rs_en = '0; dif.in_rs_mat = '0;
      dif.in_payload = '0; dif.fu_release = '0; dif.wb_valid = 1'b0; dif.wb_tag = '0;
      dif.freeze = 1'b0; dif.flush = 1'b0;
   endtask

   task automatic apply(input vec_t x);
      dif.in_valid   = x.v;
      dif.in_fu      = FU_IDX_W'(x.fu);
      dif.in_rd      = SREG_W'(x.rd);
      dif.in_rd_en   = x.rd_en;
      dif.in_rd_mat  = x.rd_mat;
      dif.in_rs[0]   = SREG_W'(x.rs0);
      dif.in_rs[1]   = SREG_W'(x.rs1);
      dif.in_rs[2]   = SREG_W'(x.rs2);
      dif.in_rs_en   = x.rs_en;
      dif.in_rs_mat  = x.rs_mat;
      dif.in_payload = {$urandom, $urandom};
      dif.fu_release = x.rel;
      dif.wb_valid   = x.wbv;
      dif.wb_tag     = TAG_W'(x.wbt);
      dif.flush      = x.fl;
      dif.freeze     = x.fz;
   endtask

   function automatic void model_clear();
      foreach (srst_m[i]) srst_m[i] = 0;
      foreach (mrst_m[i]) mrst_m[i] = 0;
      busy_m = '0;
   endfunction

   function automatic int cur_tag(bit mat, int r);
      if (mat) return mrst_m[r % NMREG];
      if (r == 0) return 0;
      return srst_m[r];
   endfunction

   function automatic int src_tag(int i);
      int t;
      if (!dif.in_rs_en[i]) return 0;
      t = cur_tag(dif.in_rs_mat[i], int'(dif.in_rs[i]));
      if (dif.wb_valid && int'(dif.wb_tag) == t) t = 0;
      return t;
   endfunction

   function automatic bit exp_ready();
      int fu;
      int dt;
      bit waw;
      fu  = int'(dif.in_fu);
      dt  = dif.in_rd_en ? cur_tag(dif.in_rd_mat, int'(dif.in_rd)) : 0;
      waw = (dt != 0) && !(dif.wb_valid && int'(dif.wb_tag) == dt);
      if (dif.freeze || dif.flush || waw || fu >= NFU) return 1'b0;
      return !(busy_m[fu] && !dif.fu_release[fu]);
   endfunction

   task automatic check_model(input string nm);
      bit       r;
      bit [4:0] ewe;
      r   = exp_ready();
      ewe = (dif.in_valid && r) ? 5'(1 << int'(dif.in_fu)) : 5'd0;
      chk({nm, "_ready"}, 64'(dif.in_ready), 64'(r));
      chk({nm, "_we"},    64'(dif.fust_we), 64'(ewe));
      for (int i = 0; i < 3; i++) begin
         chk({nm, "_t"}, 64'(dif.fust_t[i]), 64'(src_tag(i)));
         chk({nm, "_rs"}, 64'(dif.fust_rs[i]), 64'(dif.in_rs[i]));
      end
      chk({nm, "_rd"},   64'(dif.fust_rd), 64'(dif.in_rd));
      chk({nm, "_pay"},  dif.fust_payload, dif.in_payload);
      chk({nm, "_busy"}, 64'(dif.busy), 64'(busy_m));
      if (int'(dif.in_fu) >= NFU) begin
         checks++;
         assert (!dif.in_ready && dif.fust_we == '0)
         else begin
            errors++;
            $error("FAIL illegal_fu: got ready=%0b we=%0h, need ready=0 we=0", dif.in_ready, dif.fust_we);
         end
      end
   endtask

   // Clock edge: update the model from the inputs held across the edge.
   task automatic advance();
      bit fire;
      int fu;
      @(posedge CLK);
      fire = dif.in_valid && exp_ready();
      fu   = int'(dif.in_fu);
      if (dif.flush) begin
         model_clear();
      end else begin
         if (dif.wb_valid) begin
            foreach (srst_m[i]) if (srst_m[i] == int'(dif.wb_tag)) srst_m[i] = 0;
            foreach (mrst_m[i]) if (mrst_m[i] == int'(dif.wb_tag)) mrst_m[i] = 0;
         end
         busy_m = busy_m & ~dif.fu_release;
         if (fire) begin
            busy_m[fu] = 1'b1;
            if (dif.in_rd_en) begin
               if (dif.in_rd_mat) mrst_m[int'(dif.in_rd) % NMREG] = fu + 1;
               else if (dif.in_rd != '0) srst_m[int'(dif.in_rd)] = fu + 1;
            end
         end
      end
      #1;
   endtask

   task automatic rand_drive();
      int r;
      idle();
      dif.in_valid  = ($urandom_range(0, 3) != 0);
      r             = $urandom_range(0, 19);
      dif.in_fu     = (r < 18) ? FU_IDX_W'(r % 5) : FU_IDX_W'(5 + $urandom_range(0, 2));
      dif.in_rd     = SREG_W'($urandom_range(0, 7));
      dif.in_rd_en  = $urandom_range(0, 1) == 1;
      dif.in_rd_mat = $urandom_range(0, 3) == 0;
      for (int i = 0; i < 3; i++) begin
         dif.in_rs[i]     = SREG_W'($urandom_range(0, 7));
         dif.in_rs_en[i]  = $urandom_range(0, 1) == 1;
         dif.in_rs_mat[i] = $urandom_range(0, 3) == 0;
      end
      for (int i = 0; i < NFU; i++) dif.fu_release[i] = $urandom_range(0, 9) < 3;
      dif.in_payload = {$urandom, $urandom};
      dif.wb_valid   = $urandom_range(0, 9) < 4;
      dif.wb_tag     = TAG_W'($urandom_range(1, 5));
      dif.flush      = $urandom_range(0, 49) == 0;
      dif.freeze     = $urandom_range(0, 19) == 0;
   endtask

   vec_t tbl [17];

   initial begin
      // Directed sequence following the intended dispatch scenarios.
      //            v fu rd re rm rs0 rs1 rs2 en      mat     rel      wv wt fl fz  rdy we       t0 t1 t2 busy
      tbl[0]  = mk(1, 0, 3, 1, 0, 1, 2, 0, 3'b011, 3'b000, 5'b00000, 0, 0, 0, 0, 1, 5'b00001, 0, 0, 0, 5'b00000);
      tbl[1]  = mk(1, 0, 4, 1, 0, 3, 0, 0, 3'b001, 3'b000, 5'b00000, 0, 0, 0, 0, 0, 5'b00000, 1, 0, 0, 5'b00001);
      tbl[2]  = mk(1, 0, 4, 1, 0, 3, 0, 0, 3'b001, 3'b000, 5'b00001, 0, 0, 0, 0, 1, 5'b00001, 1, 0, 0, 5'b00001);
      tbl[3]  = mk(1, 0, 5, 1, 0, 0, 0, 0, 3'b000, 3'b000, 5'b00001, 0, 0, 0, 0, 1, 5'b00001, 0, 0, 0, 5'b00001);
      tbl[4]  = mk(1, 1, 6, 1, 0, 5, 0, 0, 3'b001, 3'b000, 5'b00000, 0, 0, 0, 0, 1, 5'b00010, 1, 0, 0, 5'b00001);
      tbl[5]  = mk(1, 1, 7, 1, 0, 5, 0, 0, 3'b001, 3'b000, 5'b00010, 1, 1, 0, 0, 1, 5'b00010, 0, 0, 0, 5'b00011);
      tbl[6]  = mk(1, 2, 7, 1, 0, 0, 0, 0, 3'b000, 3'b000, 5'b00000, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 0, 5'b00011);
      tbl[7]  = mk(1, 2, 7, 1, 0, 0, 0, 0, 3'b000, 3'b000, 5'b00000, 1, 2, 0, 0, 1, 5'b00100, 0, 0, 0, 5'b00011);
      tbl[8]  = mk(0, 0, 0, 0, 0, 7, 6, 5, 3'b111, 3'b000, 5'b00000, 0, 0, 0, 0, 0, 5'b00000, 3, 0, 0, 5'b00111);
      tbl[9]  = mk(1, 3, 1, 1, 1, 0, 0, 0, 3'b000, 3'b000, 5'b00000, 0, 0, 0, 0, 1, 5'b01000, 0, 0, 0, 5'b00111);
      tbl[10] = mk(1, 4, 2, 1, 1, 0, 1, 3, 3'b111, 3'b111, 5'b00000, 0, 0, 0, 0, 1, 5'b10000, 0, 4, 0, 5'b01111);
      tbl[11] = mk(1, 0, 0, 1, 0, 0, 0, 0, 3'b001, 3'b000, 5'b00001, 0, 0, 0, 0, 1, 5'b00001, 0, 0, 0, 5'b11111);
      tbl[12] = mk(1, 0, 0, 1, 0, 2, 1, 0, 3'b111, 3'b011, 5'b00001, 0, 0, 0, 0, 1, 5'b00001, 5, 4, 0, 5'b11111);
      tbl[13] = mk(1, 0, 9, 1, 0, 2, 1, 0, 3'b111, 3'b011, 5'b00001, 0, 0, 1, 0, 0, 5'b00000, 5, 4, 0, 5'b11111);
      tbl[14] = mk(0, 0, 0, 0, 0, 2, 1, 7, 3'b111, 3'b011, 5'b00000, 0, 0, 0, 0, 1, 5'b00000, 0, 0, 0, 5'b00000);
      tbl[15] = mk(0, 5, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 5'b00000, 0, 0, 0, 0, 0, 5'b00000, 0, 0, 0, 5'b00000);
      tbl[16] = mk(1, 1, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 5'b00000, 0, 0, 0, 1, 0, 5'b00000, 0, 0, 0, 5'b00000);

      idle();
      model_clear();
      nRST = 1'b0;
      #22;
      chk("reset_busy",  64'(dif.busy), 64'd0);
      chk("reset_ready", 64'(dif.in_ready), 64'd1);
      chk("reset_we",    64'(dif.fust_we), 64'd0);
      nRST = 1'b1;
      @(posedge CLK);
      #1;

      for (int k = 0; k < 17; k++) begin
         apply(tbl[k]);
         @(negedge CLK);
         chk($sformatf("vec%0d_ready", k), 64'(dif.in_ready), 64'(tbl[k].e_ready));
         chk($sformatf("vec%0d_we", k),    64'(dif.fust_we), 64'(tbl[k].e_we));
         chk($sformatf("vec%0d_t0", k),    64'(dif.fust_t[0]), 64'(tbl[k].e_t0));
         chk($sformatf("vec%0d_t1", k),    64'(dif.fust_t[1]), 64'(tbl[k].e_t1));
         chk($sformatf("vec%0d_t2", k),    64'(dif.fust_t[2]), 64'(tbl[k].e_t2));
         chk($sformatf("vec%0d_busy", k),  64'(dif.busy), 64'(tbl[k].e_busy));
         check_model($sformatf("vec%0d_m", k));
         advance();
      end

      // Randomized traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         rand_drive();
         @(negedge CLK);
         check_model("rand");
         advance();
      end

      // Async reset in the middle of a cycle with live state.
      idle();
      dif.flush = 1'b1;
      @(negedge CLK);
      check_model("pre_rst_flush");
      advance();
      idle();
      dif.in_valid = 1'b1; dif.in_fu = 3'd0; dif.in_rd = 5'd3; dif.in_rd_en = 1'b1;
      @(negedge CLK);
      check_model("pre_rst_fire");
      advance();
      idle();
      dif.in_rs[0] = 5'd3; dif.in_rs_en = 3'b001;
      #2;
      chk("pre_rst_busy",  64'(dif.busy), 64'b00001);
      chk("pre_rst_t0",    64'(dif.fust_t[0]), 64'd1);
      chk("pre_rst_ready", 64'(dif.in_ready), 64'd0);
      nRST = 1'b0;
      #1;
      chk("async_rst_busy",  64'(dif.busy), 64'd0);
      chk("async_rst_t0",    64'(dif.fust_t[0]), 64'd0);
      chk("async_rst_ready", 64'(dif.in_ready), 64'd1);
      chk("async_rst_we",    64'(dif.fust_we), 64'd0);
      model_clear();
      @(negedge CLK);
      nRST = 1'b1;
      advance();
      for (int c = 0; c < 200; c++) begin
         rand_drive();
         @(negedge CLK);
         check_model("post_rst");
         advance();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
